// File: rtl/vga_bus_pkg.sv
// Shared VGA bus definitions: register offsets, default screen limits and the
// rectangle filler state encoding.
package vga_bus_pkg;

  localparam logic [7:0] VGA_BASE_ADDR = 8'hB0;

  localparam logic [1:0] OFS_X    = 2'd0;
  localparam logic [1:0] OFS_Y    = 2'd1;
  localparam logic [1:0] OFS_DATA = 2'd2;

  localparam int WE_BIT = 7;

  localparam logic [7:0] X_MAX_DEF = 8'd159;
  localparam logic [6:0] Y_MAX_DEF = 7'd119;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SET_DATA,
    ST_SET_X,
    ST_SET_YWE,
    ST_CLR_WE,
    ST_FIN
  } filler_state_e;

  function automatic logic [7:0] reg_addr(input logic [7:0] base, input logic [1:0] ofs);
    return base + {6'd0, ofs};
  endfunction

endpackage

// File: rtl/vga_rect_filler_if.sv
// Command handshake and bus-control signals of the rectangle filler.
// slave = the filler itself, master = the command issuer / bus environment.
interface vga_rect_filler_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x0;
  logic [7:0] cmd_x1;
  logic [6:0] cmd_y0;
  logic [6:0] cmd_y1;
  logic       cmd_colour;
  logic       busy;
  logic       done;
  logic       bus_req;
  logic       bus_gnt;
  logic [7:0] bus_addr;
  logic       bus_we;

  modport slave (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_colour, bus_gnt,
    output cmd_ready, busy, done, bus_req, bus_addr, bus_we
  );

  modport master (
    output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_colour, bus_gnt,
    input  cmd_ready, busy, done, bus_req, bus_addr, bus_we
  );

endinterface

// File: rtl/vga_rect_scan.sv
// Loadable raster position counter: x runs x0..x1, then y advances and x
// returns to x0. Termination is by compare so x1=255 / y1=127 never wrap.
module vga_rect_scan (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [6:0] y0,
  input  logic [6:0] y1,
  output logic [7:0] x,
  output logic [7:0] x_nxt,
  output logic [6:0] y,
  output logic       last
);

  logic [7:0] x_q, x_d, x0_q, x0_d, x1_q, x1_d;
  logic [6:0] y_q, y_d, y1_q, y1_d;
  logic       row_end;
  logic [6:0] y_nxt;

  always_comb begin
    row_end = (x_q == x1_q);
    x_nxt   = row_end ? x0_q : x_q + 8'd1;
    y_nxt   = row_end ? y_q + 7'd1 : y_q;
    x_d     = x_q;
    y_d     = y_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    if (load) begin
      x_d  = x0;
      y_d  = y0;
      x0_d = x0;
      x1_d = x1;
      y1_d = y1;
    end else if (step) begin
      x_d = x_nxt;
      y_d = y_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= 8'd0;
      y_q  <= 7'd0;
      x0_q <= 8'd0;
      x1_q <= 8'd0;
      y1_q <= 7'd0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      x0_q <= x0_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = row_end && (y_q == y1_q);

endmodule

// File: rtl/vga_rect_filler.sv
// Bus initiator filling a rectangle of the 1-bit frame buffer through the VGA
// peripheral registers. Optional coordinate clipping: VGA_RECT_CLIP_EN.
//
// state    | meaning
// IDLE     | ready for a command
// REQ      | bus requested, waiting for grant
// SET_DATA | write colour to BASE+2 (once per command)
// SET_X    | write x to BASE
// SET_YWE  | write {1,y} to BASE+1, pixel stored
// CLR_WE   | write {0,y} to BASE+1
// FIN      | DONE pulse, bus released, ready again
module vga_rect_filler
  import vga_bus_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = VGA_BASE_ADDR,
  parameter logic [7:0] X_MAX     = X_MAX_DEF,
  parameter logic [6:0] Y_MAX     = Y_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_rect_filler_if.slave  io,
  inout  wire  [7:0]        bus_data
);

`ifdef VGA_RECT_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [7:0] X_LIM = CLIP_EN ? X_MAX : 8'hFF;
  localparam logic [6:0] Y_LIM = CLIP_EN ? Y_MAX : 7'h7F;

  filler_state_e state_q, state_d, wr_state;
  logic       stall_q, stall_d, drive_q, drive_d, we_q, we_d;
  logic       req_q, req_d, ready_q, ready_d, busy_q, busy_d;
  logic       done_q, done_d, colour_q, colour_d;
  logic [7:0] addr_q, addr_d, data_q, data_d;
  logic       accept, empty, present, scan_load, scan_step, scan_last;
  logic [7:0] x0_c, x1_c, x_cur, x_nxt;
  logic [6:0] y0_c, y1_c, y_cur;

  always_comb begin
    x0_c  = (io.cmd_x0 > X_LIM) ? X_LIM : io.cmd_x0;
    x1_c  = (io.cmd_x1 > X_LIM) ? X_LIM : io.cmd_x1;
    y0_c  = (io.cmd_y0 > Y_LIM) ? Y_LIM : io.cmd_y0;
    y1_c  = (io.cmd_y1 > Y_LIM) ? Y_LIM : io.cmd_y1;
    accept = io.cmd_valid & ready_q;
    empty  = (x0_c > x1_c) | (y0_c > y1_c);
  end

  vga_rect_scan u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (scan_load),
    .step  (scan_step),
    .x0    (x0_c),
    .x1    (x1_c),
    .y0    (y0_c),
    .y1    (y1_c),
    .x     (x_cur),
    .x_nxt (x_nxt),
    .y     (y_cur),
    .last  (scan_last)
  );

  // A write is accepted when grant is sampled high at the end of its cycle;
  // after a stall the same state re-presents its write before advancing.
  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    req_d     = req_q;
    done_d    = 1'b0;
    colour_d  = colour_q;
    scan_load = 1'b0;
    scan_step = 1'b0;
    present   = 1'b0;
    wr_state  = state_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        stall_d = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        req_d   = 1'b0;
        if (accept) begin
          scan_load = 1'b1;
          colour_d  = io.cmd_colour;
          if (empty) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_REQ;
            ready_d = 1'b0;
            busy_d  = 1'b1;
            req_d   = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (io.bus_gnt) begin
          present  = 1'b1;
          wr_state = ST_SET_DATA;
          state_d  = ST_SET_DATA;
        end
      end
      default: begin
        if (!io.bus_gnt) begin
          stall_d = 1'b1;
        end else if (stall_q) begin
          stall_d = 1'b0;
          present = 1'b1;
        end else begin
          present = 1'b1;
          case (state_q)
            ST_SET_DATA: wr_state = ST_SET_X;
            ST_SET_X:    wr_state = ST_SET_YWE;
            ST_SET_YWE:  wr_state = ST_CLR_WE;
            default: begin
              if (scan_last) begin
                present  = 1'b0;
                wr_state = ST_FIN;
                done_d   = 1'b1;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                req_d    = 1'b0;
              end else begin
                wr_state  = ST_SET_X;
                scan_step = 1'b1;
              end
            end
          endcase
          state_d = wr_state;
        end
      end
    endcase
  end

  always_comb begin
    drive_d = present;
    we_d    = present;
    addr_d  = 8'h00;
    data_d  = 8'h00;
    if (present) begin
      case (wr_state)
        ST_SET_DATA: begin
          addr_d = reg_addr(BASE_ADDR, OFS_DATA);
          data_d = {7'd0, colour_q};
        end
        ST_SET_X: begin
          addr_d = reg_addr(BASE_ADDR, OFS_X);
          data_d = scan_step ? x_nxt : x_cur;
        end
        ST_SET_YWE: begin
          addr_d         = reg_addr(BASE_ADDR, OFS_Y);
          data_d         = {1'b0, y_cur};
          data_d[WE_BIT] = 1'b1;
        end
        default: begin
          addr_d = reg_addr(BASE_ADDR, OFS_Y);
          data_d = {1'b0, y_cur};
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      stall_q  <= 1'b0;
      drive_q  <= 1'b0;
      we_q     <= 1'b0;
      req_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      colour_q <= 1'b0;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      drive_q  <= drive_d;
      we_q     <= we_d;
      req_q    <= req_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      colour_q <= colour_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign io.cmd_ready = ready_q;
  assign io.busy      = busy_q;
  assign io.done      = done_q;
  assign io.bus_req   = req_q;
  assign io.bus_we    = we_q;
  assign io.bus_addr  = addr_q;
  assign bus_data     = drive_q ? data_q : 8'hzz;

endmodule

// File: tb/tb_vga_rect_filler.sv
// Directed bench for vga_rect_filler: expected bus writes are queued by the
// stimulus and consumed by an independent bus monitor.
module tb_vga_rect_filler;

  logic       clk = 1'b0;
  logic       rst_n;
  wire  [7:0] bus_data;

  vga_rect_filler_if ifc ();

  vga_rect_filler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (ifc),
    .bus_data (bus_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] last_x, last_y;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    sb.push_back(w);
  endtask

  task automatic push_rect(input int x0, input int x1, input int y0, input int y1,
                           input bit col, output int npix);
`ifdef VGA_RECT_CLIP_EN
    if (x0 > 159) x0 = 159;
    if (x1 > 159) x1 = 159;
    if (y0 > 119) y0 = 119;
    if (y1 > 119) y1 = 119;
`endif
    npix = 0;
    if (x0 > x1 || y0 > y1) return;
    push(8'hB2, {7'd0, col});
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        push(8'hB0, 8'(x));
        push(8'hB1, 8'h80 | 8'(y));
        push(8'hB1, 8'(y));
        npix++;
      end
    end
  endtask

  // Monitor: every write the arbiter sees (WE with grant) must match the queue head.
  always @(negedge clk) begin
    if (rst_n && ifc.bus_we && ifc.bus_gnt) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h=%0h expected none", ifc.bus_addr, bus_data);
      end else begin
        wr_t w;
        w = sb.pop_front();
        chk("bus_write", {ifc.bus_addr, bus_data}, {w.a, w.d});
      end
      if (ifc.bus_addr == 8'hB0) last_x = bus_data;
      if (ifc.bus_addr == 8'hB1 && !bus_data[7]) last_y = bus_data;
    end
  end

  task automatic issue(input logic [7:0] x0, input logic [7:0] x1,
                       input logic [6:0] y0, input logic [6:0] y1, input bit col);
    int guard;
    @(negedge clk);
    ifc.cmd_x0 = x0;
    ifc.cmd_x1 = x1;
    ifc.cmd_y0 = y0;
    ifc.cmd_y1 = y1;
    ifc.cmd_colour = col;
    ifc.cmd_valid = 1'b1;
    guard = 0;
    while (!ifc.cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1 ifc.cmd_valid = 1'b0;
  endtask

  // Counts cycles after accept (cycle 1 = first cycle after the accept edge).
  task automatic wait_done(input int n0, output int n);
    n = n0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifc.done && n < 5000);
    if (!ifc.done) chk("done_timeout", 0, 1);
  endtask

  int n, npix;

  initial begin
    rst_n = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_x0 = 8'd0;
    ifc.cmd_x1 = 8'd0;
    ifc.cmd_y0 = 7'd0;
    ifc.cmd_y1 = 7'd0;
    ifc.cmd_colour = 1'b0;
    ifc.bus_gnt = 1'b1;
    last_x = 8'h00;
    last_y = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {ifc.cmd_ready, ifc.busy, ifc.done, ifc.bus_req, ifc.bus_we},
        5'b10000);
    chk("rst_addr", ifc.bus_addr, 8'h00);
    rst_n = 1'b1;

    // single pixel
    push(8'hB2, 8'h01);
    push(8'hB0, 8'h05);
    push(8'hB1, 8'h83);
    push(8'hB1, 8'h03);
    issue(8'd5, 8'd5, 7'd3, 7'd3, 1'b1);
    @(negedge clk);
    chk("t1_cycle1", {ifc.bus_req, ifc.busy, ifc.cmd_ready, ifc.bus_we}, 4'b1100);
    wait_done(1, n);
    chk("t1_done_cycle", n, 6);
    chk("t1_ready_at_done", ifc.cmd_ready, 1'b1);
    chk("t1_req_at_done", ifc.bus_req, 1'b0);
    chk("t1_left", sb.size(), 0);

    // 3x2 rectangle, colour 0, grant lost during SET_YWE of pixel 2
    push_rect(0, 2, 0, 1, 1'b0, npix);
    issue(8'd0, 8'd2, 7'd0, 7'd1, 1'b0);
    repeat (6) @(posedge clk);
    #1 ifc.bus_gnt = 1'b0;
    @(negedge clk);
    chk("t2_presented", {ifc.bus_we, ifc.bus_addr, bus_data}, {1'b1, 8'hB1, 8'h80});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_released", {ifc.bus_we, ifc.bus_addr, ifc.bus_req}, {1'b0, 8'h00, 1'b1});
      if (k == 2) begin
        @(posedge clk);
        #1 ifc.bus_gnt = 1'b1;
      end
    end
    wait_done(11, n);
    chk("t2_done_cycle", n, 26);
    chk("t2_left", sb.size(), 0);

    // empty command
    issue(8'd10, 8'd9, 7'd0, 7'd0, 1'b1);
    wait_done(0, n);
    chk("t3_done_cycle", n, 1);
    chk("t3_req", ifc.bus_req, 1'b0);

    // top-edge rectangle: terminates by compare at x=255, y=127
    push_rect(254, 255, 126, 127, 1'b1, npix);
    issue(8'd254, 8'd255, 7'd126, 7'd127, 1'b1);
    wait_done(0, n);
    chk("t4_done_cycle", n, 3 * npix + 3);
    chk("t4_left", sb.size(), 0);

    // clip behaviour
    push_rect(150, 200, 110, 127, 1'b1, npix);
    issue(8'd150, 8'd200, 7'd110, 7'd127, 1'b1);
    wait_done(0, n);
    chk("t5_done_cycle", n, 3 * npix + 3);
    chk("t5_left", sb.size(), 0);
`ifdef VGA_RECT_CLIP_EN
    chk("t5_last_x", last_x, 8'h9F);
    chk("t5_last_y", last_y, 8'h77);
`else
    chk("t5_last_x", last_x, 8'hC8);
    chk("t5_last_y", last_y, 8'h7F);
`endif

    // asynchronous reset mid-command
    push_rect(0, 3, 0, 3, 1'b1, npix);
    issue(8'd0, 8'd3, 7'd0, 7'd3, 1'b1);
    repeat (8) @(negedge clk);
    chk("t6_active", {ifc.bus_req, ifc.busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_outputs", {ifc.bus_req, ifc.bus_we, ifc.busy, ifc.cmd_ready}, 4'b0001);
    chk("t6_async_addr", ifc.bus_addr, 8'h00);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // normal operation after reset
    push_rect(7, 8, 2, 2, 1'b0, npix);
    issue(8'd7, 8'd8, 7'd2, 7'd2, 1'b0);
    wait_done(0, n);
    chk("t7_done_cycle", n, 9);
    chk("t7_left", sb.size(), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
